serial_adder: RTL



---
 rtl/serial_adder_if.sv | 36 +++
 rtl/serial_adder.sv | 129 ++++++++++++
 2 files changed

// File: rtl/serial_adder_if.sv
// Request/result bundle for serial_adder: operands and start in, status and result out.
// The requester holds the master modport; the adder holds the slave modport.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start,
    output a,
    output b,
    output c_in,
    input  busy,
    input  done,
    input  sum,
    input  c_out
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    input  c_in,
    output busy,
    output done,
    output sum,
    output c_out
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell with a registered carry loop, LSB first.
// Captures operands on start, adds one bit per clock, then pulses done with sum/c_out held.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c_in,
  output logic o_s,
  output logic o_c_out
);
  assign o_s     = i_a ^ i_b ^ i_c_in;
  assign o_c_out = (i_a & i_b) | (i_c_in & (i_a ^ i_b));
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave io_bus
);
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e            r_state;
  state_e            w_state;
  logic [WIDTH-1:0]  r_a_sh;
  logic [WIDTH-1:0]  w_a_sh;
  logic [WIDTH-1:0]  r_b_sh;
  logic [WIDTH-1:0]  w_b_sh;
  logic [WIDTH-1:0]  r_sum_sh;
  logic [WIDTH-1:0]  w_sum_sh;
  logic              r_carry;
  logic              w_carry;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cnt;
  logic [WIDTH-1:0]  r_sum;
  logic [WIDTH-1:0]  w_sum;
  logic              r_c_out;
  logic              w_c_out;

  logic              w_fa_s;
  logic              w_fa_c_out;
  logic [WIDTH-1:0]  w_sum_shifted;

  full_adder u_fa (
    .i_a     (r_a_sh[0]),
    .i_b     (r_b_sh[0]),
    .i_c_in  (r_carry),
    .o_s     (w_fa_s),
    .o_c_out (w_fa_c_out)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts the LSB sits at bit 0.
  assign w_sum_shifted = {w_fa_s, r_sum_sh[WIDTH-1:1]};

  always_comb begin
    w_state  = r_state;
    w_a_sh   = r_a_sh;
    w_b_sh   = r_b_sh;
    w_sum_sh = r_sum_sh;
    w_carry  = r_carry;
    w_cnt    = r_cnt;
    w_sum    = r_sum;
    w_c_out  = r_c_out;
    unique case (r_state)
      StIdle: begin
        if (io_bus.start) begin
          w_a_sh   = io_bus.a;
          w_b_sh   = io_bus.b;
          w_carry  = io_bus.c_in;
          w_sum_sh = '0;
          w_cnt    = '0;
          w_state  = StShift;
        end
      end
      StShift: begin
        w_sum_sh = w_sum_shifted;
        w_a_sh   = r_a_sh >> 1;
        w_b_sh   = r_b_sh >> 1;
        w_carry  = w_fa_c_out;
        w_cnt    = r_cnt + CntW'(1);
        if (r_cnt == LastCnt) begin
          w_sum   = w_sum_shifted;
          w_c_out = w_fa_c_out;
          w_state = StDone;
        end
      end
      StDone: begin
        w_state = StIdle;
      end
      default: begin
        w_state = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_c_out  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_a_sh   <= w_a_sh;
      r_b_sh   <= w_b_sh;
      r_sum_sh <= w_sum_sh;
      r_carry  <= w_carry;
      r_cnt    <= w_cnt;
      r_sum    <= w_sum;
      r_c_out  <= w_c_out;
    end
  end

  assign io_bus.busy  = (r_state == StShift) || (r_state == StDone);
  assign io_bus.done  = (r_state == StDone);
  assign io_bus.sum   = r_sum;
  assign io_bus.c_out = r_c_out;
endmodule
